// File: rtl/dmem_wait_responder.sv
// rtl/dmem_wait_responder.sv - wait-state data-memory responder with req/ack handshake
//
// Ports:
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_req               request valid, held with stable fields until o_ack
//   i_we                1 = store, 0 = load
//   i_addr              byte address
//   i_wdata             store data
//   i_be                byte-lane enables for stores (bit n = byte n)
//   o_busy              high from the first wait cycle through the ack cycle
//   o_ack               one-cycle completion pulse
//   o_rdata             load data, valid with o_ack (0 for stores and errors)
//   o_err               misaligned-access flag, valid with o_ack
//   o_err_cnt           saturating count of errored transactions
module dmem_wait_responder #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 11,
  parameter int P_WAIT_CYCLES     = 1,
  parameter int P_ERR_CNT_WIDTH   = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_req,
  input  logic                         i_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_wdata,
  input  logic [3:0]                   i_be,
  output logic                         o_busy,
  output logic                         o_ack,
  output logic [P_DATA_WIDTH-1:0]      o_rdata,
  output logic                         o_err,
  output logic [P_ERR_CNT_WIDTH-1:0]   o_err_cnt
);

  localparam int          L_WORD_AW = P_DMEM_ADDR_WIDTH - 2;
  localparam int          L_DEPTH   = 1 << L_WORD_AW;
  localparam logic [3:0]  L_WAIT    = 4'(P_WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                         state;
  logic [3:0]                     wait_cnt;

  // Captured transaction; live inputs are never looked at after capture.
  logic                           cap_we;
  logic [P_DMEM_ADDR_WIDTH-1:0]   cap_addr;
  logic [P_DATA_WIDTH-1:0]        cap_wdata;
  logic [3:0]                     cap_be;

  logic [P_DATA_WIDTH-1:0]        mem [L_DEPTH];

  logic                           access;
  logic                           misaligned;
  logic                           mem_we;
  logic [L_WORD_AW-1:0]           word_idx;

  assign access     = (state == S_WAIT) && (wait_cnt == 4'd0);
  assign misaligned = (cap_addr[1:0] != 2'b00);
  assign word_idx   = cap_addr[P_DMEM_ADDR_WIDTH-1:2];
  // Reset on the access edge must discard the transaction, so it gates the write.
  assign mem_we     = access && !i_rst && cap_we && !misaligned;

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_be[b]) begin
          mem[word_idx][8*b +: 8] <= cap_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      wait_cnt  <= 4'd0;
      o_busy    <= 1'b0;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_rdata   <= '0;
      o_err_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          o_busy  <= 1'b0;
          o_ack   <= 1'b0;
          o_err   <= 1'b0;
          o_rdata <= '0;
          if (i_req) begin
            cap_we    <= i_we;
            cap_addr  <= i_addr;
            cap_wdata <= i_wdata;
            cap_be    <= i_be;
            wait_cnt  <= L_WAIT;
            o_busy    <= 1'b1;
            state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Access edge: the store (if any) commits in the storage block above.
            o_ack <= 1'b1;
            o_err <= misaligned;
            state <= S_RESP;
            if (misaligned) begin
              o_rdata <= '0;
              if (o_err_cnt != {P_ERR_CNT_WIDTH{1'b1}}) begin
                o_err_cnt <= o_err_cnt + 1'b1;
              end
            end else if (cap_we) begin
              o_rdata <= '0;
            end else begin
              o_rdata <= mem[word_idx];
            end
          end
        end

        S_RESP: begin
          o_ack   <= 1'b0;
          o_busy  <= 1'b0;
          o_err   <= 1'b0;
          o_rdata <= '0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_wait_responder.sv
// tb/tb_dmem_wait_responder.sv - scoreboard bench for dmem_wait_responder
module tb_dmem_wait_responder;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: one wait state. Instance B: three wait states.
  logic        rst_a, req_a, we_a, busy_a, ack_a, err_a;
  logic [10:0] addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [3:0]  be_a;
  logic [7:0]  cnt_a;

  logic        rst_b, req_b, we_b, busy_b, ack_b, err_b;
  logic [10:0] addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic [3:0]  be_b;
  logic [7:0]  cnt_b;

  dmem_wait_responder #(.P_WAIT_CYCLES(1)) u_dut_a (
    .i_clk(clk), .i_rst(rst_a), .i_req(req_a), .i_we(we_a), .i_addr(addr_a),
    .i_wdata(wdata_a), .i_be(be_a), .o_busy(busy_a), .o_ack(ack_a),
    .o_rdata(rdata_a), .o_err(err_a), .o_err_cnt(cnt_a)
  );

  dmem_wait_responder #(.P_WAIT_CYCLES(3)) u_dut_b (
    .i_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_we(we_b), .i_addr(addr_b),
    .i_wdata(wdata_b), .i_be(be_b), .o_busy(busy_b), .o_ack(ack_b),
    .o_rdata(rdata_b), .o_err(err_b), .o_err_cnt(cnt_b)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input bit sel, input int c, input logic [31:0] rd,
                      input logic er, input logic [7:0] cn);
    exp_t e;
    e.cyc = c; e.rdata = rd; e.err = er; e.cnt = cn;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Monitors: pop one expectation per observed ack.
  always @(negedge clk) begin
    if (ack_a === 1'b1) begin
      if (q_a.size() == 0) begin
        chk("a_unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        chk("a_ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("a_rdata", 64'(rdata_a), 64'(e.rdata));
        chk("a_err", 64'(err_a), 64'(e.err));
        chk("a_err_cnt", 64'(cnt_a), 64'(e.cnt));
        chk("a_busy_at_ack", 64'(busy_a), 64'd1);
      end
    end
  end

  always @(negedge clk) begin
    if (ack_b === 1'b1) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_ack", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_ack_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_rdata", 64'(rdata_b), 64'(e.rdata));
        chk("b_err", 64'(err_b), 64'(e.err));
        chk("b_err_cnt", 64'(cnt_b), 64'(e.cnt));
        chk("b_busy_at_ack", 64'(busy_b), 64'd1);
      end
    end
  end

  task automatic drive(input bit sel, input logic rq, input logic we,
                       input logic [10:0] ad, input logic [31:0] wd, input logic [3:0] be);
    if (sel) begin req_b = rq; we_b = we; addr_b = ad; wdata_b = wd; be_b = be; end
    else     begin req_a = rq; we_a = we; addr_a = ad; wdata_a = wd; be_a = be; end
  endtask

  // One complete transaction: request, expected ack pushed, wait for ack, drop req.
  task automatic txn(input bit sel, input logic we, input logic [10:0] ad,
                     input logic [31:0] wd, input logic [3:0] be,
                     input logic [31:0] rd, input logic er, input logic [7:0] cn);
    int  w;
    bit  got;
    w   = sel ? 3 : 1;
    got = 1'b0;
    @(posedge clk); #1;
    drive(sel, 1'b1, we, ad, wd, be);
    push(sel, cyc + w + 2, rd, er, cn);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if ((sel ? ack_b : ack_a) === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("txn_timeout", 64'd0, 64'd1);
    drive(sel, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
  endtask

  initial begin
    int n;
    int acks;
    drive(1'b0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    drive(1'b1, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_ack", 64'(ack_a), 64'd0);
    chk("rst_err", 64'(err_a), 64'd0);
    chk("rst_rdata", 64'(rdata_a), 64'd0);
    chk("rst_err_cnt", 64'(cnt_a), 64'd0);
    chk("rst_b_busy", 64'(busy_b), 64'd0);

    // Full-word store and load, ack three cycles after request
    txn(0, 1'b1, 11'h010, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, 8'd0);
    txn(0, 1'b0, 11'h010, 32'h0, 4'b0000, 32'hDEADBEEF, 1'b0, 8'd0);
    // Single byte lane
    txn(0, 1'b1, 11'h010, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 8'd0);
    txn(0, 1'b0, 11'h010, 32'h0, 4'b1111, 32'hDEADAAEF, 1'b0, 8'd0);
    // Misaligned store is suppressed and counted
    txn(0, 1'b1, 11'h013, 32'h12345678, 4'b1111, 32'h0, 1'b1, 8'd1);
    txn(0, 1'b0, 11'h010, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0, 8'd1);
    // be=0000 store is a clean no-op
    txn(0, 1'b1, 11'h010, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 8'd1);
    txn(0, 1'b0, 11'h010, 32'h0, 4'b0000, 32'hDEADAAEF, 1'b0, 8'd1);
    // Misaligned load
    txn(0, 1'b0, 11'h012, 32'h0, 4'b0000, 32'h0, 1'b1, 8'd2);

    // Three wait states: busy window and dropped request
    txn(1, 1'b1, 11'h040, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, 8'd0);
    @(posedge clk); #1;
    n = cyc;
    drive(1, 1'b1, 1'b0, 11'h040, 32'h0, 4'b0000);
    push(1, n + 5, 32'h0BADF00D, 1'b0, 8'd0);
    chk("b_busy_c0", 64'(busy_b), 64'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      if (k == 2) drive(1, 1'b0, 1'b1, 11'h013, 32'hFFFFFFFF, 4'b1111);
      chk($sformatf("b_busy_c%0d", k), 64'(busy_b), (k <= 5) ? 64'd1 : 64'd0);
    end
    txn(1, 1'b0, 11'h040, 32'h0, 4'b0000, 32'h0BADF00D, 1'b0, 8'd0);

    // Reset on the access edge of a store discards it
    txn(0, 1'b1, 11'h020, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, 8'd2);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 11'h020, 32'h55555555, 4'b1111);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    chk("mid_rst_ack", 64'(ack_a), 64'd0);
    chk("mid_rst_busy", 64'(busy_a), 64'd0);
    chk("mid_rst_err", 64'(err_a), 64'd0);
    chk("mid_rst_rdata", 64'(rdata_a), 64'd0);
    chk("mid_rst_err_cnt", 64'(cnt_a), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_ack", 64'(ack_a), 64'd0);
    txn(0, 1'b0, 11'h020, 32'h0, 4'b0000, 32'hCAFEF00D, 1'b0, 8'd0);

    // 300 back-to-back misaligned loads, counter saturates
    @(posedge clk); #1;
    n = cyc;
    drive(0, 1'b1, 1'b0, 11'h011, 32'h0, 4'b0000);
    for (int k = 0; k < 300; k++) begin
      push(0, n + 3 + 4 * k, 32'h0, 1'b1, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
    end
    acks = 0;
    for (int i = 0; i < 1300 && acks < 300; i++) begin
      @(posedge clk); #1;
      if (ack_a === 1'b1) begin
        acks++;
        if (acks == 300) drive(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
      end
    end
    drive(0, 1'b0, 1'b0, 11'h0, 32'h0, 4'h0);
    chk("b2b_ack_count", 64'(acks), 64'd300);
    repeat (8) @(posedge clk);
    #1;
    chk("final_err_cnt", 64'(cnt_a), 64'd255);
    chk("q_a_drained", 64'(q_a.size()), 64'd0);
    chk("q_b_drained", 64'(q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
